// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t    : FSM state encoding (IDLE, SHIFT, DONE)
//   BCD_DIGITS : number of packed BCD digits produced
//   BCD_MAX    : largest value representable in BCD_DIGITS digits
//   BCD_SAT    : pattern shown on the display when the input saturates
//   digit_needs_adj : true when a BCD digit must be corrected before a shift
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int          BCD_DIGITS = 4;
  localparam int          BCD_MAX    = 9999;
  localparam logic [15:0] BCD_SAT    = 16'h9999;

  // A digit of 5 or more would become >= 10 after doubling, so it needs +3
  // before the shift to carry correctly into the next digit.
  function automatic logic digit_needs_adj(input logic [3:0] digit);
    return digit >= 4'd5;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Combinational BCD digit corrector used by the shift-and-add-3 datapath.
//   digit_in  : current 4-bit BCD digit of the scratch register
//   digit_out : digit_in + 3 when digit_in >= 5, otherwise digit_in
// Inputs above 9 never occur in a valid scratch register, so the 4-bit add
// cannot wrap for the digits that reach it (5..9 map to 8..12).
module bcd_add3
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = digit_needs_adj(digit_in) ? (digit_in + 4'd3) : digit_in;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) that drives the
// Data[15:0]/Load inputs of the seven-segment display interface.
//   clk     : system clock, rising edge
//   rst     : asynchronous active-low reset, released synchronously to clk
//   start   : conversion request, only honoured while idle
//   bin_in  : unsigned binary value captured when start is accepted
//   bcd_out : packed BCD result, [3:0] units .. [15:12] thousands, held
//   load    : one-cycle pulse coinciding with each bcd_out update
//   busy    : high from the accepting edge until the result is loaded
//   ovf     : set with bcd_out when the captured value exceeded 9999
// Latency from the accepting edge to load is WIDTH+1 cycles, independent
// of the value, including the saturating case.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int WIDTH = 14  // legal range 4..14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bin_in,
  output logic [15:0]      bcd_out,
  output logic             load,
  output logic             busy,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state_reg,    state_next;
  logic [WIDTH-1:0] shift_reg,    shift_next;
  logic [15:0]      scratch_reg,  scratch_next;
  logic [CNT_W-1:0] cnt_reg,      cnt_next;
  logic             sat_reg,      sat_next;
  logic [15:0]      bcd_reg,      bcd_next;
  logic             load_reg,     load_next;
  logic             busy_reg,     busy_next;
  logic             ovf_reg,      ovf_next;

  logic [15:0]      scratch_adj;
  logic [16:0]      scratch_shifted;
  logic [31:0]      bin_ext;
  logic             bin_too_big;

  // One corrector per BCD digit of the scratch register.
  generate
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
      bcd_add3 u_add3 (
        .digit_in  (scratch_reg[gi*4 +: 4]),
        .digit_out (scratch_adj[gi*4 +: 4])
      );
    end
  endgenerate

  // Corrected scratch shifted left with the next binary bit entering at the
  // bottom. Bit 16 is the digit carry-out; it is dropped because any value
  // large enough to produce it is already flagged for saturation.
  assign scratch_shifted = {scratch_adj, shift_reg[WIDTH-1]};

  assign bin_ext     = 32'(bin_in);
  assign bin_too_big = bin_ext > 32'(BCD_MAX);

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    scratch_next = scratch_reg;
    cnt_next     = cnt_reg;
    sat_next     = sat_reg;
    bcd_next     = bcd_reg;
    load_next    = 1'b0;
    busy_next    = busy_reg;
    ovf_next     = ovf_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          shift_next   = bin_in;
          scratch_next = '0;
          sat_next     = bin_too_big;
          cnt_next     = CNT_W'(WIDTH - 1);
          busy_next    = 1'b1;
          state_next   = SHIFT;
        end
      end

      SHIFT: begin
        scratch_next = scratch_shifted[15:0];
        shift_next   = {shift_reg[WIDTH-2:0], 1'b0};
        if (cnt_reg == '0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      DONE: begin
        bcd_next   = sat_reg ? BCD_SAT : scratch_reg;
        ovf_next   = sat_reg;
        load_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      scratch_reg <= '0;
      cnt_reg     <= '0;
      sat_reg     <= 1'b0;
      bcd_reg     <= '0;
      load_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      scratch_reg <= scratch_next;
      cnt_reg     <= cnt_next;
      sat_reg     <= sat_next;
      bcd_reg     <= bcd_next;
      load_reg    <= load_next;
      busy_reg    <= busy_next;
      ovf_reg     <= ovf_next;
    end
  end

  assign bcd_out = bcd_reg;
  assign load    = load_reg;
  assign busy    = busy_reg;
  assign ovf     = ovf_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (WIDTH = 14).
module tb_bin_to_bcd_seq;

  localparam int WIDTH   = 14;
  localparam int LATENCY = WIDTH + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] bin_in = '0;
  logic [15:0]      bcd_out;
  logic             load;
  logic             busy;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .bcd_out (bcd_out),
    .load    (load),
    .busy    (busy),
    .ovf     (ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decimal digits by plain arithmetic; saturate above 9999.
  function automatic logic [15:0] ref_bcd(input int v);
    int d3, d2, d1, d0;
    if (v > 9999) return 16'h9999;
    d3 = v / 1000;
    d2 = (v / 100) % 10;
    d1 = (v / 10) % 10;
    d0 = v % 10;
    return 16'((d3 << 12) | (d2 << 8) | (d1 << 4) | d0);
  endfunction

  // Behavioural model: a request is accepted only when no conversion is
  // outstanding; its result appears LATENCY edges later.
  int          m_rem = 0;
  int          m_pend = 0;
  logic [15:0] m_bcd = '0;
  logic        m_load = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_ovf = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rem  <= 0;
      m_pend <= 0;
      m_bcd  <= '0;
      m_load <= 1'b0;
      m_busy <= 1'b0;
      m_ovf  <= 1'b0;
    end else begin
      m_load <= 1'b0;
      if (m_rem == 0) begin
        if (start) begin
          m_rem  <= LATENCY;
          m_pend <= int'(bin_in);
          m_busy <= 1'b1;
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_load <= 1'b1;
          m_bcd  <= ref_bcd(m_pend);
          m_ovf  <= (m_pend > 9999);
          m_busy <= 1'b0;
        end
      end
    end
  end

  // Per-cycle compare against the model, plus display-interface properties.
  bit          checking = 0;
  logic [15:0] prev_bcd = '0;
  int          load_count = 0;

  always @(posedge clk) begin
    #1;
    if (checking) begin
      chk("bcd_out", 32'(bcd_out), 32'(m_bcd));
      chk("load", 32'(load), 32'(m_load));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      if (rst && !load) chk("bcd_stable", 32'(bcd_out), 32'(prev_bcd));
    end
    prev_bcd = bcd_out;
    if (load) load_count++;
  end

  task automatic run_conv(input int v, output logic [15:0] got_bcd, output logic got_ovf,
                          output int lat, output int busy_cycles);
    @(negedge clk);
    start  = 1'b1;
    bin_in = WIDTH'(v);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    busy_cycles = 0;
    for (int k = 1; k <= 40; k++) begin
      if (load) begin
        lat = k - 1;
        break;
      end
      if (busy) busy_cycles++;
      @(negedge clk);
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: no load within 40 cycles for value %0d", v);
    end
    got_bcd = bcd_out;
    got_ovf = ovf;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] g_bcd;
    logic        g_ovf;
    int          lat, bcyc, lc;
    int          edge_vals[11] = '{1, 9, 99, 100, 999, 1000, 9998, 9999, 10000, 10001, 16383};

    // Model pins
    chk("ref_pin_1234", 32'(ref_bcd(1234)), 32'h1234);
    chk("ref_pin_10", 32'(ref_bcd(10)), 32'h0010);
    chk("ref_pin_12000", 32'(ref_bcd(12000)), 32'h9999);

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bcd", 32'(bcd_out), 32'h0);
    chk("rst_load", 32'(load), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    checking = 1;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Zero: latency, busy duration, single load
    lc = load_count;
    run_conv(0, g_bcd, g_ovf, lat, bcyc);
    chk("zero_bcd", 32'(g_bcd), 32'h0000);
    chk("zero_ovf", 32'(g_ovf), 32'h0);
    chk("zero_latency", 32'(lat), 32'd15);
    chk("zero_busy_cycles", 32'(bcyc), 32'd15);
    chk("zero_loads", 32'(load_count - lc), 32'd1);
    $display("conv 0 -> %h ovf=%0d lat=%0d", g_bcd, g_ovf, lat);

    run_conv(1234, g_bcd, g_ovf, lat, bcyc);
    chk("v1234_bcd", 32'(g_bcd), 32'h1234);
    $display("conv 1234 -> %h ovf=%0d lat=%0d", g_bcd, g_ovf, lat);
    run_conv(9999, g_bcd, g_ovf, lat, bcyc);
    chk("v9999_bcd", 32'(g_bcd), 32'h9999);
    chk("v9999_ovf", 32'(g_ovf), 32'h0);
    $display("conv 9999 -> %h ovf=%0d lat=%0d", g_bcd, g_ovf, lat);
    run_conv(10, g_bcd, g_ovf, lat, bcyc);
    chk("v10_bcd", 32'(g_bcd), 32'h0010);
    $display("conv 10 -> %h ovf=%0d lat=%0d", g_bcd, g_ovf, lat);
    run_conv(12000, g_bcd, g_ovf, lat, bcyc);
    chk("v12000_bcd", 32'(g_bcd), 32'h9999);
    chk("v12000_ovf", 32'(g_ovf), 32'h1);
    chk("v12000_latency", 32'(lat), 32'd15);
    $display("conv 12000 -> %h ovf=%0d lat=%0d", g_bcd, g_ovf, lat);
    run_conv(42, g_bcd, g_ovf, lat, bcyc);
    chk("v42_bcd", 32'(g_bcd), 32'h0042);
    chk("v42_ovf", 32'(g_ovf), 32'h0);
    $display("conv 42 -> %h ovf=%0d lat=%0d", g_bcd, g_ovf, lat);

    // Start while busy is ignored
    lc = load_count;
    @(negedge clk);
    start = 1'b1;
    bin_in = WIDTH'(1234);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    bin_in = WIDTH'(5678);
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk("busy_ignore_loads", 32'(load_count - lc), 32'd1);
    chk("busy_ignore_bcd", 32'(bcd_out), 32'h1234);
    $display("start-while-busy -> loads=%0d bcd=%h", load_count - lc, bcd_out);

    // Start held high: back-to-back conversions
    lc = load_count;
    @(negedge clk);
    start = 1'b1;
    bin_in = WIDTH'(7);
    repeat (48) @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("held_start_loads", 32'(load_count - lc), 32'd3);
    chk("held_start_bcd", 32'(bcd_out), 32'h0007);
    $display("held start -> loads=%0d bcd=%h", load_count - lc, bcd_out);

    // Reset mid-conversion
    @(negedge clk);
    start = 1'b1;
    bin_in = WIDTH'(999);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_bcd", 32'(bcd_out), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_load", 32'(load), 32'h0);
    chk("abort_ovf", 32'(ovf), 32'h0);
    lc = load_count;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_load", 32'(load_count - lc), 32'd0);
    $display("reset abort -> loads after abort=%0d", load_count - lc);
    run_conv(321, g_bcd, g_ovf, lat, bcyc);
    chk("v321_bcd", 32'(g_bcd), 32'h0321);
    chk("v321_latency", 32'(lat), 32'd15);
    $display("conv 321 -> %h ovf=%0d lat=%0d", g_bcd, g_ovf, lat);

    // Boundary values
    foreach (edge_vals[i]) begin
      run_conv(edge_vals[i], g_bcd, g_ovf, lat, bcyc);
      chk("edge_bcd", 32'(g_bcd), 32'(ref_bcd(edge_vals[i])));
      chk("edge_ovf", 32'(g_ovf), 32'(edge_vals[i] > 9999));
      $display("conv %0d -> %h ovf=%0d lat=%0d", edge_vals[i], g_bcd, g_ovf, lat);
    end

    // Strided sweep across 0..9999
    for (int v = 0; v <= 9999; v += 13) begin
      run_conv(v, g_bcd, g_ovf, lat, bcyc);
      chk("sweep_bcd", 32'(g_bcd), 32'(ref_bcd(v)));
      $display("sweep %0d -> %h", v, g_bcd);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
